iter_down_counter: RTL and testbench
====================================

// Module: iter_down_counter
// PURPOSE
//  Parametrised iteration counter for sequential multipliers and dividers.
//  Loads an iteration count, steps it down by STEP per enabled cycle, and pulses done at terminal count.
//  Adds busy/done handshaking, pause, clamped underflow and error flags.
//  Sits beside the multiplier datapath; the controller FSM drives ld/dec and waits for done.
// PARAMETERS
//  WIDTH  8  counter and load-value width in bits (>=2)
//  STEP   1  decrement per accepted step, 1..2**WIDTH-1
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset
//  ld         in   1      load load_val and start a run
//  load_val   in   WIDTH  iteration count to load
//  dec        in   1      step request
//  hold       in   1      pause; blocks dec while high
//  count      out  WIDTH  current count (registered)
//  busy       out  1      high while state==RUN
//  done       out  1      one-cycle pulse; high while state==DONE
//  clamp      out  1      sticky: a step was clamped to 0 (count<STEP); cleared by ld
//  err        out  1      sticky: dec while not RUN; cleared by ld
// BEHAVIOUR
//  Reset (reset==0, async): count=0, state=IDLE, busy=0, done=0, clamp=0, err=0.
//  State register states: IDLE, RUN, DONE. busy and done decode from state; count and flags are registered.
//  Priority each edge: ld > (dec & ~hold) > hold.
//  ld (any state): count<=load_val; clamp<=0; err<=0.
//   - load_val!=0: next state RUN.
//   - load_val==0: next state DONE, so done pulses.
//  RUN, dec & ~hold:
//   - count>STEP: count<=count-STEP; stay RUN.
//   - count==STEP: count<=0; next state DONE.
//   - count<STEP: count<=0; clamp<=1; next state DONE.
//  RUN, hold or ~dec: count and state hold.
//  DONE: lasts exactly 1 cycle; next state IDLE unless ld.
//  IDLE/DONE, dec & ~ld: count unchanged; err<=1.
//  Arithmetic is unsigned at WIDTH bits. No wrap below 0, ever.
//  Latency: edge after the terminal step, count==0 and done==1 together.
//  Reset mid-run aborts immediately; no done pulse is emitted.
// CONFIGURATION
//  Macro ITER_CNT_RELOAD_EN:
//   - defined: adds input auto_reload (1 bit) and an internal WIDTH-bit reload register, written on every ld.
//     On a terminal step with auto_reload==1, count<=reload value and state stays RUN.
//     done is still a one-cycle registered pulse: a separate flop, set by the terminal step.
//     With auto_reload==0, behaviour matches the undefined case.
//   - undefined: no auto_reload port and no reload register. done decodes from state==DONE.
// STRUCTURE
//  Package iter_cnt_pkg: state enum typedef (IDLE, RUN, DONE) and the 2-bit state width constant.
//  Single module; no sub-module is warranted.
// TESTING (WIDTH=8; STEP=1 unless noted)
//  1. ld with load_val=5, then dec=1 held
//     -> count 5,4,3,2,1,0 on successive edges; busy=1 from the load edge;
//        done=1 for exactly the one cycle where count==0; busy=0 there; IDLE after.
//  2. load_val=5, dec=1; hold=1 for 3 cycles at count=3
//     -> count stays 3 for 3 cycles, then resumes 2,1,0; done pulses once.
//  3. STEP=3, ld with load_val=7, dec=1
//     -> count 7,4,1,0; clamp=1 on the final edge; done pulses; clamp clears on next ld.
//  4. ld load_val=0 -> next edge done=1, count=0, busy never high;
//     then dec=1 in IDLE -> err=1, count stays 0; ld load_val=2 -> err=0.
//  5. Run at count=2, assert ld load_val=9 with dec=1 -> count=9 (ld wins), state RUN.
//     Drop reset mid-run at count=4 -> count=0, busy=0, done=0 immediately, without waiting for clk.
//  6. ITER_CNT_RELOAD_EN defined, auto_reload=1, load_val=2, dec=1
//     -> count 2,1,2,1,2...; done pulses every 2nd cycle; busy stays 1.

Source files
------------

// File: rtl/iter_cnt_pkg.sv
// Package: iter_cnt_pkg
// Shared types for the iteration down-counter: the controller state
// encoding and its width. Imported by iter_down_counter.
package iter_cnt_pkg;

  // Width of the state register.
  localparam int STATE_W = 2;

  // Counter life cycle: idle, counting down, one-cycle terminal state.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : iter_cnt_pkg

// File: rtl/iter_down_counter.sv
// Module: iter_down_counter
// Iteration counter for sequential multipliers/dividers. A load starts a
// run, each accepted step subtracts STEP, and a one-cycle done pulse marks
// the terminal count. Steps that would go below zero are clamped to zero
// and flagged; steps requested outside a run raise a sticky error flag.
//
// Optional feature macro: ITER_CNT_RELOAD_EN
//   When defined, an auto_reload input and a reload register are added.
//   A terminal step with auto_reload high reloads the last loaded value
//   and keeps the counter running, while done still pulses for one cycle
//   from its own flop.
module iter_down_counter
  import iter_cnt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  input  logic             hold,
`ifdef ITER_CNT_RELOAD_EN
  input  logic             auto_reload,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             clamp,
  output logic             err
);

  // Step size and zero at counter width; all arithmetic stays unsigned.
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  // Registered state.
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             clamp_q, clamp_d;
  logic             err_q,   err_d;

  // Decoded step conditions.
  logic             step_en_s;   // a step request that hold does not block
  logic             is_term_s;   // this step reaches or passes zero
  logic             is_clamp_s;  // this step would pass below zero

`ifdef ITER_CNT_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q,   done_d;
  logic             reload_hit_s;  // terminal step that reloads instead of stopping
`endif

  assign step_en_s  = dec & ~hold;
  assign is_term_s  = (count_q <= STEP_W);
  assign is_clamp_s = (count_q <  STEP_W);

  // Next-state logic: load has priority over an accepted step, which has
  // priority over hold. Terminal steps force the count to exactly zero.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    clamp_d = clamp_q;
    err_d   = err_q;
`ifdef ITER_CNT_RELOAD_EN
    reload_d     = reload_q;
    reload_hit_s = 1'b0;
`endif

    if (ld) begin
      count_d = load_val;
      clamp_d = 1'b0;
      err_d   = 1'b0;
`ifdef ITER_CNT_RELOAD_EN
      reload_d = load_val;
`endif
      if (load_val != ZERO_W) begin
        state_d = ST_RUN;
      end else begin
        // An empty run completes immediately so the controller still sees done.
        state_d = ST_DONE;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (step_en_s) begin
            if (!is_term_s) begin
              count_d = count_q - STEP_W;
              state_d = ST_RUN;
            end else begin
              if (is_clamp_s) begin
                clamp_d = 1'b1;
              end else begin
                clamp_d = clamp_q;
              end
`ifdef ITER_CNT_RELOAD_EN
              if (auto_reload) begin
                count_d      = reload_q;
                state_d      = ST_RUN;
                reload_hit_s = 1'b1;
              end else begin
                count_d = ZERO_W;
                state_d = ST_DONE;
              end
`else
              count_d = ZERO_W;
              state_d = ST_DONE;
`endif
            end
          end else begin
            // Paused or no request: everything holds.
            count_d = count_q;
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          // Terminal state lasts exactly one cycle.
          state_d = ST_IDLE;
          if (step_en_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
          if (step_en_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end
        default: begin
          // Unreachable encoding: recover to a safe idle, zero count.
          state_d = ST_IDLE;
          count_d = ZERO_W;
        end
      endcase
    end
  end

`ifdef ITER_CNT_RELOAD_EN
  // Done pulse source: every entry into DONE plus every reloading terminal step.
  always_comb begin
    if ((state_d == ST_DONE) || reload_hit_s) begin
      done_d = 1'b1;
    end else begin
      done_d = 1'b0;
    end
  end
`endif

  // State, count and sticky-flag registers; reset aborts any run at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= ZERO_W;
      clamp_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      clamp_q <= clamp_d;
      err_q   <= err_d;
    end
  end

`ifdef ITER_CNT_RELOAD_EN
  // Reload value and the separate done flop used when reloading.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_q <= ZERO_W;
      done_q   <= 1'b0;
    end else begin
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign done = done_q;
`else
  assign done = (state_q == ST_DONE);
`endif

  assign count = count_q;
  assign busy  = (state_q == ST_RUN);
  assign clamp = clamp_q;
  assign err   = err_q;

endmodule : iter_down_counter

// File: tb/tb_iter_down_counter.sv
// Testbench: tb_iter_down_counter
// Drives two counters (STEP=1 and STEP=3, WIDTH=8) from shared inputs and
// compares both against a behavioural model after every clock edge.
// Honours ITER_CNT_RELOAD_EN when defined.
module tb_iter_down_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld;
  logic [7:0] load_val;
  logic       dec;
  logic       hold;
  logic       ar;

  logic [7:0] cnt1, cnt3;
  logic       busy1, done1, clamp1, err1;
  logic       busy3, done3, clamp3, err3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iter_down_counter #(.WIDTH(8), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .ld(ld), .load_val(load_val), .dec(dec), .hold(hold),
`ifdef ITER_CNT_RELOAD_EN
    .auto_reload(ar),
`endif
    .count(cnt1), .busy(busy1), .done(done1), .clamp(clamp1), .err(err1)
  );

  iter_down_counter #(.WIDTH(8), .STEP(3)) dut3 (
    .clk(clk), .reset(reset), .ld(ld), .load_val(load_val), .dec(dec), .hold(hold),
`ifdef ITER_CNT_RELOAD_EN
    .auto_reload(ar),
`endif
    .count(cnt3), .busy(busy3), .done(done3), .clamp(clamp3), .err(err3)
  );

  // Behavioural model: remaining iterations, running flag, done pulse.
  typedef struct {
    int cnt;
    int rl;
    bit run;
    bit done;
    bit clamp;
    bit err;
  } mdl_t;

  mdl_t m1, m3;

  function automatic mdl_t mreset();
    mdl_t m;
    m.cnt = 0; m.rl = 0; m.run = 0; m.done = 0; m.clamp = 0; m.err = 0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int step, bit l, int lv, bit d, bit h, bit rel);
    mdl_t n = m;
    n.done = 0;
    if (l) begin
      n.cnt = lv; n.rl = lv; n.clamp = 0; n.err = 0;
      n.run = (lv != 0);
      n.done = (lv == 0);
    end else if (d && !h) begin
      if (m.run) begin
        if (m.cnt - step > 0) begin
          n.cnt = m.cnt - step;
        end else begin
          if (m.cnt - step < 0) n.clamp = 1;
          n.done = 1;
          if (rel) begin
            n.cnt = m.rl;
          end else begin
            n.cnt = 0;
            n.run = 0;
          end
        end
      end else begin
        n.err = 1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".s1.count"}, {24'd0, cnt1},   m1.cnt);
    chk({tag, ".s1.busy"},  {31'd0, busy1},  {31'd0, m1.run});
    chk({tag, ".s1.done"},  {31'd0, done1},  {31'd0, m1.done});
    chk({tag, ".s1.clamp"}, {31'd0, clamp1}, {31'd0, m1.clamp});
    chk({tag, ".s1.err"},   {31'd0, err1},   {31'd0, m1.err});
    chk({tag, ".s3.count"}, {24'd0, cnt3},   m3.cnt);
    chk({tag, ".s3.busy"},  {31'd0, busy3},  {31'd0, m3.run});
    chk({tag, ".s3.done"},  {31'd0, done3},  {31'd0, m3.done});
    chk({tag, ".s3.clamp"}, {31'd0, clamp3}, {31'd0, m3.clamp});
    chk({tag, ".s3.err"},   {31'd0, err3},   {31'd0, m3.err});
  endtask

  // One clock: inputs are applied at the negedge, model advances at the
  // posedge, outputs are compared at the following negedge.
  task automatic cyc(input string tag, input bit l, input int lv, input bit d, input bit h);
    bit rel;
    ld = l; load_val = 8'(lv); dec = d; hold = h;
    @(posedge clk);
`ifdef ITER_CNT_RELOAD_EN
    rel = ar;
`else
    rel = 1'b0;
`endif
    m1 = mstep(m1, 1, l, lv, d, h, rel);
    m3 = mstep(m3, 3, l, lv, d, h, rel);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0; ld = 1'b0; load_val = 8'd0; dec = 1'b0; hold = 1'b0; ar = 1'b0;
    m1 = mreset(); m3 = mreset();
    #2;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // 1: load 5, dec held down to zero, then idle.
    cyc("t1.ld", 1'b1, 5, 1'b0, 1'b0);
    chk("t1.ld_count_lit", {24'd0, cnt1}, 32'd5);
    chk("t1.ld_busy_lit", {31'd0, busy1}, 32'd1);
    for (int i = 0; i < 5; i++) cyc("t1.dec", 1'b0, 0, 1'b1, 1'b0);
    chk("t1.done_lit", {31'd0, done1}, 32'd1);
    chk("t1.zero_lit", {24'd0, cnt1}, 32'd0);
    cyc("t1.idle", 1'b0, 0, 1'b0, 1'b0);
    chk("t1.done_once_lit", {31'd0, done1}, 32'd0);

    // 2: hold for 3 cycles at count 3.
    cyc("t2.ld", 1'b1, 5, 1'b0, 1'b0);
    cyc("t2.dec", 1'b0, 0, 1'b1, 1'b0);
    cyc("t2.dec", 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("t2.hold", 1'b0, 0, 1'b1, 1'b1);
    chk("t2.held_lit", {24'd0, cnt1}, 32'd3);
    for (int i = 0; i < 3; i++) cyc("t2.resume", 1'b0, 0, 1'b1, 1'b0);
    cyc("t2.idle", 1'b0, 0, 1'b0, 1'b0);

    // 3: load 7 -> STEP=3 instance clamps on the final step.
    cyc("t3.ld", 1'b1, 7, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("t3.dec", 1'b0, 0, 1'b1, 1'b0);
    chk("t3.clamp_lit", {31'd0, clamp3}, 32'd1);
    cyc("t3.idle", 1'b0, 0, 1'b0, 1'b0);
    cyc("t3.reld", 1'b1, 4, 1'b0, 1'b0);
    chk("t3.clamp_clr_lit", {31'd0, clamp3}, 32'd0);

    // 4: empty load, dec while idle, error cleared by a fresh load.
    cyc("t4.ld0", 1'b1, 0, 1'b0, 1'b0);
    chk("t4.done_lit", {31'd0, done1}, 32'd1);
    chk("t4.busy_lit", {31'd0, busy1}, 32'd0);
    cyc("t4.gap", 1'b0, 0, 1'b0, 1'b0);
    cyc("t4.err", 1'b0, 0, 1'b1, 1'b0);
    chk("t4.err_lit", {31'd0, err1}, 32'd1);
    cyc("t4.ld2", 1'b1, 2, 1'b0, 1'b0);
    chk("t4.err_clr_lit", {31'd0, err1}, 32'd0);

    // 5: load wins over dec mid-run; async reset mid-run.
    cyc("t5.ld", 1'b1, 2, 1'b0, 1'b0);
    cyc("t5.ldwin", 1'b1, 9, 1'b1, 1'b0);
    chk("t5.ldwin_lit", {24'd0, cnt1}, 32'd9);
    for (int i = 0; i < 5; i++) cyc("t5.dec", 1'b0, 0, 1'b1, 1'b0);
    chk("t5.at4_lit", {24'd0, cnt1}, 32'd4);
    #2;
    reset = 1'b0;
    #1;
    m1 = mreset(); m3 = mreset();
    check_all("t5.async_rst");
    @(negedge clk);
    reset = 1'b1;
    dec = 1'b0;
    cyc("t5.after", 1'b0, 0, 1'b0, 1'b0);

`ifdef ITER_CNT_RELOAD_EN
    // 6: auto-reload keeps running and pulses done every 2nd cycle.
    ar = 1'b1;
    cyc("t6.ld", 1'b1, 2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc("t6.dec", 1'b0, 0, 1'b1, 1'b0);
    chk("t6.busy_lit", {31'd0, busy1}, 32'd1);
    ar = 1'b0;
    cyc("t6.ld_off", 1'b1, 0, 1'b0, 1'b0);
`endif

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      bit rl;
      bit rd;
      bit rh;
      int lv;
      rl = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 9) < 7);
      rh = ($urandom_range(0, 4) == 0);
      lv = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
`ifdef ITER_CNT_RELOAD_EN
      ar = ($urandom_range(0, 3) == 0);
`endif
      cyc("rand", rl, lv, rd, rh);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_iter_down_counter
